int_ctrl_p: RTL

- Memory-mapped interrupt controller for the peripheral interrupt lines (push buttons, switches, timer, ...), e.g. the OR-reduced push-button interrupt.
- Edge-detects up to NUM_SRC sources into a pending register and applies a software mask.
- Arbitrates by fixed priority, then presents one request at a time to the CPU using a req/ack/EOI handshake.
- Sits on the peripheral bus beside the other *_p blocks, using the same 16-word, registered-read port style.

---
 rtl/int_ctrl_p_if.sv | 24 ++
 rtl/int_ctrl_p.sv | 105 ++++++++++
 2 files changed

// File: rtl/int_ctrl_p_if.sv
// Peripheral-bus register port plus interrupt lines and CPU req/ack handshake for int_ctrl_p.
// master = bus/CPU side, slave = interrupt controller.
interface int_ctrl_p_if #(
  parameter int NUM_SRC = 8
);
  logic [3:0]         addra;
  logic [31:0]        dina;
  logic               wea;
  logic [31:0]        douta;
  logic [NUM_SRC-1:0] int_src;
  logic               int_ack;
  logic               int_req;
  logic [3:0]         int_id;

  modport master (
    output addra, dina, wea, int_src, int_ack,
    input  douta, int_req, int_id
  );

  modport slave (
    input  addra, dina, wea, int_src, int_ack,
    output douta, int_req, int_id
  );
endinterface

// File: rtl/int_ctrl_p.sv
// Interrupt controller: rising-edge pending latch, software mask, fixed priority (bit 0 highest).
// One-cycle registered reads; the CPU paces requests via req/ack and an EOI write.
module int_ctrl_p #(
  parameter int NUM_SRC = 8
) (
  input  logic        clk,
  input  logic        rst,
  int_ctrl_p_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] prev_src, pending, pending_n, mask, rise, eligible;
  logic               req_q, req_n;
  logic [3:0]         id_q, id_n, first_id;
  logic [31:0]        dout_q, rd_dat;
  logic               wr_pend, wr_mask, wr_eoi;
  logic               unused_dina;

  assign rise     = bus.int_src & ~prev_src;
  assign eligible = pending & mask;
  assign wr_pend  = bus.wea && (bus.addra == 4'd0);
  assign wr_mask  = bus.wea && (bus.addra == 4'd1);
  assign wr_eoi   = bus.wea && (bus.addra == 4'd3);

  assign unused_dina = &{1'b0, bus.dina[31:NUM_SRC]};

  assign bus.int_req = req_q;
  assign bus.int_id  = id_q;
  assign bus.douta   = dout_q;

  // Scan downward so the lowest-numbered eligible source wins.
  always_comb begin
    first_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) first_id = 4'(i);
    end
  end

  always_comb begin
    state_n = state;
    req_n   = req_q;
    id_n    = id_q;
    case (state)
      IDLE: begin
        if (|eligible) begin
          id_n    = first_id;
          req_n   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          req_n   = 1'b0;
          state_n = SVC;
        end
      end
      SVC: begin
        if (wr_eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Set beats W1C; the acknowledge clear beats a same-cycle rise.
  always_comb begin
    pending_n = pending;
    if (wr_pend) pending_n = pending_n & ~bus.dina[NUM_SRC-1:0];
    pending_n = pending_n | rise;
    if (state == REQ && bus.int_ack) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (id_q == 4'(i)) pending_n[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    case (bus.addra)
      4'd0:    rd_dat = 32'(pending);
      4'd1:    rd_dat = 32'(mask);
      4'd2:    rd_dat = {state == SVC, req_q, 26'b0, id_q};
      default: rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    prev_src <= bus.int_src;
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      mask    <= '0;
      req_q   <= 1'b0;
      id_q    <= '0;
      dout_q  <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      if (wr_mask) mask <= bus.dina[NUM_SRC-1:0];
      req_q   <= req_n;
      id_q    <= id_n;
      dout_q  <= rd_dat;
    end
  end
endmodule
